multi_lift_hall_call_panel: RTL and testbench

Requesting end of the multi-lift floor-request interface: turns raw per-floor hall-call buttons (up/down) into latched, debounced call requests that drive the arbiter's request inputs, and clears each call once a lift has served it. Sits between the landing button/lamp hardware and the multi-lift controller. It consumes the per-lift door_open, direction and floor_sense outputs to detect service.

---
 rtl/multi_lift_pkg.sv | 8 +
 rtl/hall_button_debouncer.sv | 39 +++
 rtl/multi_lift_hall_call_panel.sv | 90 +++++++++
 tb/tb_multi_lift_hall_call_panel.sv | 160 ++++++++++++++++
 4 files changed

// File: rtl/multi_lift_pkg.sv
// Constants and types shared by the hall-call panel and the multi-lift controller.
package multi_lift_pkg;
  localparam logic DIR_UP   = 1'b1;
  localparam logic DIR_DN   = 1'b0;
  localparam int   DB_CNT_W = 8;

  typedef enum logic {CALL_IDLE = 1'b0, CALL_PENDING = 1'b1} call_state_t;
endpackage

// File: rtl/hall_button_debouncer.sv
// One hall button: 2-flop synchronizer, saturating debounce counter, one-shot press.
module hall_button_debouncer
  import multi_lift_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic btn,
  output logic press
);
  localparam logic [DB_CNT_W-1:0] CNT_MAX = DB_CNT_W'(DEBOUNCE_CYCLES);

  logic                s1, s2;
  logic [1:0]          vld_pipe;
  logic                armed;
  logic [DB_CNT_W-1:0] cnt;

  // armed only sets once a real low has passed the synchronizer, so a
  // button held through reset cannot register until released.
  always_ff @(posedge clk) begin
    if (reset) begin
      s1       <= 1'b0;
      s2       <= 1'b0;
      vld_pipe <= '0;
      armed    <= 1'b0;
      cnt      <= '0;
    end else begin
      s1       <= btn;
      s2       <= s1;
      vld_pipe <= {vld_pipe[0], 1'b1};
      if (vld_pipe[1] && !s2) armed <= 1'b1;
      if (!s2 || !armed)      cnt <= '0;
      else if (cnt != CNT_MAX) cnt <= cnt + 1'b1;
    end
  end

  assign press = s2 && armed && (cnt == CNT_MAX - 1'b1);
endmodule

// File: rtl/multi_lift_hall_call_panel.sv
// Hall-call panel: debounced up/down calls latched until a lift serves them.
module multi_lift_hall_call_panel
  import multi_lift_pkg::*;
#(
  parameter int N_FLOORS        = 12,
  parameter int N_LIFTS         = 10,
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic [N_FLOORS-1:0]               btn_up,
  input  logic [N_FLOORS-1:0]               btn_dn,
  input  logic [N_LIFTS-1:0]                door_open,
  input  logic [N_LIFTS-1:0]                direction,
  input  logic [N_LIFTS-1:0][N_FLOORS-1:0]  floor_sense,
  output logic [N_FLOORS-1:0]               hall_rqst_up,
  output logic [N_FLOORS-1:0]               hall_rqst_dn,
  output logic [N_FLOORS-1:0]               lamp_up,
  output logic [N_FLOORS-1:0]               lamp_dn,
  output logic                              served_pulse
);
  logic [N_FLOORS-1:0] serve_up, serve_dn, clr_up, clr_dn;
  logic                unused_ok;

  assign unused_ok = &{1'b0, btn_up[N_FLOORS-1], btn_dn[0]};

  // End floors accept either travel direction.
  always_comb begin
    serve_up = '0;
    serve_dn = '0;
    for (int l = 0; l < N_LIFTS; l++) begin
      for (int f = 0; f < N_FLOORS; f++) begin
        if (door_open[l] && floor_sense[l][f]) begin
          if (direction[l] == DIR_UP || f == 0)          serve_up[f] = 1'b1;
          if (direction[l] == DIR_DN || f == N_FLOORS-1) serve_dn[f] = 1'b1;
        end
      end
    end
  end

  for (genvar f = 0; f < N_FLOORS; f++) begin : g_floor
    if (f < N_FLOORS-1) begin : g_up
      call_state_t st;
      logic        press;

      hall_button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db (
        .clk(clk), .reset(reset), .btn(btn_up[f]), .press(press));

      always_ff @(posedge clk) begin
        if (reset) st <= CALL_IDLE;
        else if (st == CALL_PENDING && serve_up[f]) st <= CALL_IDLE;
        else if (st == CALL_IDLE && press && !serve_up[f]) st <= CALL_PENDING;
      end

      assign hall_rqst_up[f] = (st == CALL_PENDING);
      assign clr_up[f]       = (st == CALL_PENDING) && serve_up[f];
    end else begin : g_up_tie
      assign hall_rqst_up[f] = 1'b0;
      assign clr_up[f]       = 1'b0;
    end

    if (f > 0) begin : g_dn
      call_state_t st;
      logic        press;

      hall_button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db (
        .clk(clk), .reset(reset), .btn(btn_dn[f]), .press(press));

      always_ff @(posedge clk) begin
        if (reset) st <= CALL_IDLE;
        else if (st == CALL_PENDING && serve_dn[f]) st <= CALL_IDLE;
        else if (st == CALL_IDLE && press && !serve_dn[f]) st <= CALL_PENDING;
      end

      assign hall_rqst_dn[f] = (st == CALL_PENDING);
      assign clr_dn[f]       = (st == CALL_PENDING) && serve_dn[f];
    end else begin : g_dn_tie
      assign hall_rqst_dn[f] = 1'b0;
      assign clr_dn[f]       = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) served_pulse <= 1'b0;
    else       served_pulse <= |{clr_up, clr_dn};
  end

  assign lamp_up = hall_rqst_up;
  assign lamp_dn = hall_rqst_dn;
endmodule

// File: tb/tb_multi_lift_hall_call_panel.sv
// Directed scenarios for the hall-call panel; expectations queued at drive, checked after the edge.
module tb_multi_lift_hall_call_panel;
  localparam int NF = 12;
  localparam int NL = 10;

  logic                clk;
  logic                reset;
  logic [NF-1:0]       btn_up, btn_dn;
  logic [NL-1:0]       door_open, direction;
  logic [NL-1:0][NF-1:0] floor_sense;
  logic [NF-1:0]       hall_rqst_up, hall_rqst_dn, lamp_up, lamp_dn;
  logic                served_pulse;

  multi_lift_hall_call_panel #(.N_FLOORS(NF), .N_LIFTS(NL), .DEBOUNCE_CYCLES(4)) dut (
    .clk(clk), .reset(reset), .btn_up(btn_up), .btn_dn(btn_dn),
    .door_open(door_open), .direction(direction), .floor_sense(floor_sense),
    .hall_rqst_up(hall_rqst_up), .hall_rqst_dn(hall_rqst_dn),
    .lamp_up(lamp_up), .lamp_dn(lamp_dn), .served_pulse(served_pulse));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string         tag;
    logic [NF-1:0] up;
    logic [NF-1:0] dn;
    logic          pulse;
  } exp_t;

  exp_t          sb[$];
  logic [NF-1:0] exp_up, exp_dn;
  int            n_tests, n_fail;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Queue the expected state for after the next edge, then advance and compare.
  task automatic step(input string tag, input logic pulse);
    exp_t e;
    sb.push_back('{tag, exp_up, exp_dn, pulse});
    @(posedge clk);
    @(negedge clk);
    while (sb.size() > 0) begin
      e = sb.pop_front();
      chk({e.tag, ".rqst_up"}, 32'(hall_rqst_up), 32'(e.up));
      chk({e.tag, ".rqst_dn"}, 32'(hall_rqst_dn), 32'(e.dn));
      chk({e.tag, ".lamp_up"}, 32'(lamp_up),      32'(e.up));
      chk({e.tag, ".lamp_dn"}, 32'(lamp_dn),      32'(e.dn));
      chk({e.tag, ".pulse"},   32'(served_pulse), 32'(e.pulse));
    end
  endtask

  // Request appears on the 6th edge after the button rises (2 sync + 4 count).
  task automatic press(input string tag, input logic [NF-1:0] bu, input logic [NF-1:0] bd);
    btn_up = btn_up | bu;
    btn_dn = btn_dn | bd;
    for (int i = 0; i < 5; i++) step(tag, 1'b0);
    exp_up = exp_up | bu;
    exp_dn = exp_dn | bd;
    step(tag, 1'b0);
    btn_up = btn_up & ~bu;
    btn_dn = btn_dn & ~bd;
    for (int i = 0; i < 4; i++) step({tag, "_rel"}, 1'b0);
  endtask

  task automatic lifts_clear();
    door_open   = '0;
    direction   = '0;
    floor_sense = '0;
  endtask

  initial begin
    n_tests = 0; n_fail = 0;
    reset = 1'b1;
    btn_up = '0; btn_dn = '0;
    lifts_clear();
    exp_up = '0; exp_dn = '0;

    step("reset", 1'b0);
    step("reset", 1'b0);
    reset = 1'b0;
    for (int i = 0; i < 4; i++) step("idle", 1'b0);

    // single press, held 10 cycles
    btn_up[3] = 1'b1;
    for (int i = 0; i < 5; i++) step("single_pre", 1'b0);
    exp_up[3] = 1'b1;
    step("single_edge6", 1'b0);
    for (int i = 0; i < 4; i++) step("single_hold", 1'b0);
    btn_up[3] = 1'b0;
    for (int i = 0; i < 4; i++) step("single_rel", 1'b0);

    // glitch: 3 high, 1 low, 3 high
    btn_dn[5] = 1'b1;
    for (int i = 0; i < 3; i++) step("glitch_a", 1'b0);
    btn_dn[5] = 1'b0;
    step("glitch_low", 1'b0);
    btn_dn[5] = 1'b1;
    for (int i = 0; i < 3; i++) step("glitch_b", 1'b0);
    btn_dn[5] = 1'b0;
    for (int i = 0; i < 5; i++) step("glitch_tail", 1'b0);

    // service clear of up[3] by lift 2; door stays open one more cycle
    floor_sense[2] = 12'h008; direction[2] = 1'b1; door_open[2] = 1'b1;
    exp_up[3] = 1'b0;
    step("svc_clear", 1'b1);
    step("svc_once", 1'b0);
    lifts_clear();
    step("svc_idle", 1'b0);

    // direction filter at floor 7
    press("dir7", 12'h080, 12'h080);
    floor_sense[4] = 12'h080; direction[4] = 1'b0; door_open[4] = 1'b1;
    exp_dn[7] = 1'b0;
    step("dir7_dn_clr", 1'b1);
    step("dir7_up_stays", 1'b0);
    lifts_clear();

    // several floors in one cycle, end-floor direction exceptions, two lifts on one floor
    press("ends", 12'h001, 12'h800);
    floor_sense[0] = 12'h001; direction[0] = 1'b0; door_open[0] = 1'b1;
    floor_sense[1] = 12'h800; direction[1] = 1'b1; door_open[1] = 1'b1;
    floor_sense[5] = 12'h080; direction[5] = 1'b1; door_open[5] = 1'b1;
    floor_sense[6] = 12'h080; direction[6] = 1'b1; door_open[6] = 1'b1;
    exp_up = '0;
    exp_dn = '0;
    step("multi_clr", 1'b1);
    step("multi_once", 1'b0);
    lifts_clear();

    // press while door already open for that direction; tied-off buttons
    floor_sense[8] = 12'h010; direction[8] = 1'b0; door_open[8] = 1'b1;
    btn_dn[4] = 1'b1; btn_up[NF-1] = 1'b1; btn_dn[0] = 1'b1;
    for (int i = 0; i < 8; i++) step("door_open_press", 1'b0);
    btn_dn = '0; btn_up = '0;
    lifts_clear();
    for (int i = 0; i < 4; i++) step("door_open_rel", 1'b0);

    // reset mid-operation
    press("pre_rst", 12'h002, 12'h200);
    btn_up[4] = 1'b1;
    for (int i = 0; i < 3; i++) step("mid_debounce", 1'b0);
    reset = 1'b1;
    exp_up = '0; exp_dn = '0;
    step("mid_reset", 1'b0);
    reset = 1'b0;
    for (int i = 0; i < 10; i++) step("held_after_rst", 1'b0);
    btn_up[4] = 1'b0;
    for (int i = 0; i < 4; i++) step("rst_release", 1'b0);
    press("repress", 12'h010, 12'h000);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
